// File: rtl/yarp_wb_writer_if.sv
// yarp_wb_writer_if: producer handshakes and register file write port of the writeback writer
interface yarp_wb_writer_if #(parameter int CNT_W = 16);
  logic             ex_valid_i;
  logic [4:0]       ex_rd_i;
  logic [31:0]      ex_data_i;
  logic             ex_ready_o;
  logic             ld_valid_i;
  logic [4:0]       ld_rd_i;
  logic [31:0]      ld_data_i;
  logic             ld_ready_o;
  logic [4:0]       rd_addr_o;
  logic             wr_en_o;
  logic [31:0]      wr_data_o;
  logic             busy_o;
  logic [CNT_W-1:0] wr_count_o;
  modport slave (
    input  ex_valid_i, ex_rd_i, ex_data_i, ld_valid_i, ld_rd_i, ld_data_i,
    output ex_ready_o, ld_ready_o, rd_addr_o, wr_en_o, wr_data_o, busy_o, wr_count_o
  );
  modport master (
    output ex_valid_i, ex_rd_i, ex_data_i, ld_valid_i, ld_rd_i, ld_data_i,
    input  ex_ready_o, ld_ready_o, rd_addr_o, wr_en_o, wr_data_o, busy_o, wr_count_o
  );
endinterface

// File: rtl/yarp_wb_writer.sv
// yarp_wb_writer: merges execute results and FIFO-buffered load returns into one register file write port
module yarp_wb_writer #(
  parameter int LD_DEPTH = 2,
  parameter int CNT_W    = 16
) (
  input logic              clk,
  input logic              reset,
  yarp_wb_writer_if.slave  bus
);
  localparam int PW = $clog2(LD_DEPTH);
  localparam int CW = PW + 1;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [4:0]       fifo_rd_q [LD_DEPTH];
  logic [4:0]       fifo_rd_d [LD_DEPTH];
  logic [31:0]      fifo_data_q [LD_DEPTH];
  logic [31:0]      fifo_data_d [LD_DEPTH];
  logic [4:0]       rd_addr_q, rd_addr_d;
  logic [31:0]      wr_data_q, wr_data_d;
  logic             wr_en_q, wr_en_d;
  logic [CNT_W-1:0] wr_count_q, wr_count_d;
  logic             full, push, sel_ex, pop, sel;
  logic [4:0]       sel_rd;
  logic [31:0]      sel_data;
  // Arbitration: execute wins unless the load FIFO is full, in which case the head drains
  always_comb begin
    full        = count_q == CW'(LD_DEPTH);
    push        = bus.ld_valid_i & ~full;
    sel_ex      = bus.ex_valid_i & ~full;
    pop         = (count_q != '0) & ~sel_ex;
    sel         = sel_ex | pop;
    sel_rd      = sel_ex ? bus.ex_rd_i : fifo_rd_q[rd_ptr_q];
    sel_data    = sel_ex ? bus.ex_data_i : fifo_data_q[rd_ptr_q];
    fifo_rd_d   = fifo_rd_q;
    fifo_data_d = fifo_data_q;
    if (push) begin
      fifo_rd_d[wr_ptr_q]   = bus.ld_rd_i;
      fifo_data_d[wr_ptr_q] = bus.ld_data_i;
    end
    wr_ptr_d    = wr_ptr_q + PW'(push);
    rd_ptr_d    = rd_ptr_q + PW'(pop);
    count_d     = count_q + CW'(push) - CW'(pop);
    rd_addr_d   = sel ? sel_rd : rd_addr_q;
    wr_data_d   = sel ? sel_data : wr_data_q;
    wr_en_d     = sel & (sel_rd != 5'd0);
    wr_count_d  = wr_count_q + CNT_W'(wr_en_q);
  end
  // State registers; reset discards buffered loads and any pending write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      fifo_rd_q   <= '{default: '0};
      fifo_data_q <= '{default: '0};
      rd_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_en_q     <= 1'b0;
      wr_count_q  <= '0;
    end else begin
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      fifo_rd_q   <= fifo_rd_d;
      fifo_data_q <= fifo_data_d;
      rd_addr_q   <= rd_addr_d;
      wr_data_q   <= wr_data_d;
      wr_en_q     <= wr_en_d;
      wr_count_q  <= wr_count_d;
    end
  end
  assign bus.ex_ready_o = ~full;
  assign bus.ld_ready_o = ~full;
  assign bus.rd_addr_o  = rd_addr_q;
  assign bus.wr_data_o  = wr_data_q;
  assign bus.wr_en_o    = wr_en_q;
  assign bus.wr_count_o = wr_count_q;
  assign bus.busy_o     = (count_q != '0) | wr_en_q;
endmodule

// File: tb/tb_yarp_wb_writer.sv
// tb_yarp_wb_writer: directed checks of arbitration, x0 suppression, FIFO fill/wrap and counter wrap
module tb_yarp_wb_writer;
  logic clk;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;
  int   got_rd [$];
  int   exp_rd [14] = '{21, 1, 23, 2, 3, 25, 4, 5, 27, 6, 7, 29, 8, 9};
  logic acc_ld, acc_ex;
  int   guard;
  yarp_wb_writer_if #(.CNT_W(4)) bus ();
  yarp_wb_writer #(.LD_DEPTH(2), .CNT_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask
  task automatic log_wr();
    if (bus.wr_en_o === 1'b1) begin
      got_rd.push_back(int'(bus.rd_addr_o));
      chk("wrap_data", bus.wr_data_o, 32'(bus.rd_addr_o) * 32'h11);
    end
  endtask
  initial begin
    reset = 1'b1;
    bus.ex_valid_i = 1'b0; bus.ex_rd_i = '0; bus.ex_data_i = '0;
    bus.ld_valid_i = 1'b0; bus.ld_rd_i = '0; bus.ld_data_i = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_wr_en", bus.wr_en_o, 0);
    chk("rst_rd_addr", bus.rd_addr_o, 0);
    chk("rst_wr_data", bus.wr_data_o, 0);
    chk("rst_count", bus.wr_count_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_ex_ready", bus.ex_ready_o, 1);
    chk("rst_ld_ready", bus.ld_ready_o, 1);
    reset = 1'b0;
    // execute path
    bus.ex_valid_i = 1'b1; bus.ex_rd_i = 5'd5; bus.ex_data_i = 32'hDEADBEEF;
    cyc();
    chk("ex_wr_en", bus.wr_en_o, 1);
    chk("ex_rd_addr", bus.rd_addr_o, 5);
    chk("ex_wr_data", bus.wr_data_o, 32'hDEADBEEF);
    chk("ex_busy", bus.busy_o, 1);
    bus.ex_valid_i = 1'b0;
    cyc();
    chk("ex_idle_wr_en", bus.wr_en_o, 0);
    chk("ex_count", bus.wr_count_o, 1);
    chk("ex_hold_addr", bus.rd_addr_o, 5);
    chk("ex_idle_busy", bus.busy_o, 0);
    // x0 suppression, execute then load
    bus.ex_valid_i = 1'b1; bus.ex_rd_i = 5'd0; bus.ex_data_i = 32'h12345678;
    chk("x0_ex_ready", bus.ex_ready_o, 1);
    cyc();
    chk("x0_ex_wr_en", bus.wr_en_o, 0);
    chk("x0_ex_data", bus.wr_data_o, 32'h12345678);
    chk("x0_ex_busy", bus.busy_o, 0);
    bus.ex_valid_i = 1'b0;
    bus.ld_valid_i = 1'b1; bus.ld_rd_i = 5'd0; bus.ld_data_i = 32'h55;
    chk("x0_ld_ready", bus.ld_ready_o, 1);
    cyc();
    chk("x0_ld_busy", bus.busy_o, 1);
    chk("x0_ld_wr_en0", bus.wr_en_o, 0);
    bus.ld_valid_i = 1'b0;
    cyc();
    chk("x0_ld_wr_en1", bus.wr_en_o, 0);
    chk("x0_ld_data", bus.wr_data_o, 32'h55);
    chk("x0_busy_clr", bus.busy_o, 0);
    chk("x0_count", bus.wr_count_o, 1);
    // FIFO fill under sustained execute traffic
    bus.ex_valid_i = 1'b1; bus.ex_rd_i = 5'd1; bus.ex_data_i = 32'h100;
    bus.ld_valid_i = 1'b1; bus.ld_rd_i = 5'd10; bus.ld_data_i = 32'hA;
    cyc();
    chk("fill_rd1", bus.rd_addr_o, 1);
    chk("fill_ld_ready1", bus.ld_ready_o, 1);
    bus.ex_rd_i = 5'd2; bus.ex_data_i = 32'h200;
    bus.ld_rd_i = 5'd11; bus.ld_data_i = 32'hB;
    cyc();
    chk("fill_rd2", bus.rd_addr_o, 2);
    chk("full_ld_ready", bus.ld_ready_o, 0);
    chk("full_ex_ready", bus.ex_ready_o, 0);
    bus.ex_rd_i = 5'd3; bus.ex_data_i = 32'h300;
    bus.ld_valid_i = 1'b0;
    cyc();
    chk("full_pop_rd", bus.rd_addr_o, 10);
    chk("full_pop_data", bus.wr_data_o, 32'hA);
    chk("full_pop_wr_en", bus.wr_en_o, 1);
    chk("refill_ex_ready", bus.ex_ready_o, 1);
    cyc();
    chk("resume_rd3", bus.rd_addr_o, 3);
    chk("resume_data3", bus.wr_data_o, 32'h300);
    bus.ex_rd_i = 5'd4; bus.ex_data_i = 32'h400;
    cyc();
    chk("resume_rd4", bus.rd_addr_o, 4);
    bus.ex_valid_i = 1'b0;
    cyc();
    chk("drain_rd11", bus.rd_addr_o, 11);
    chk("drain_data11", bus.wr_data_o, 32'hB);
    cyc();
    chk("fill_idle_wr_en", bus.wr_en_o, 0);
    chk("fill_idle_busy", bus.busy_o, 0);
    chk("fill_count", bus.wr_count_o, 7);
    // pointer wrap with intermittent execute traffic
    for (int i = 1; i <= 9; i++) begin
      bus.ld_valid_i = 1'b1; bus.ld_rd_i = 5'(i); bus.ld_data_i = 32'(i) * 32'h11;
      if (i % 2 == 1) begin
        bus.ex_valid_i = 1'b1; bus.ex_rd_i = 5'(20 + i); bus.ex_data_i = 32'(20 + i) * 32'h11;
      end
      guard = 0;
      do begin
        acc_ld = bus.ld_ready_o;
        acc_ex = bus.ex_ready_o & bus.ex_valid_i;
        cyc();
        log_wr();
        if (acc_ex) bus.ex_valid_i = 1'b0;
        guard++;
      end while (!acc_ld && guard < 4);
      if (!acc_ld) chk("wrap_ld_stall", 0, 1);
      bus.ld_valid_i = 1'b0;
    end
    repeat (3) begin
      cyc();
      log_wr();
    end
    chk("wrap_n_writes", got_rd.size(), 14);
    for (int k = 0; k < 14 && k < got_rd.size(); k++) chk($sformatf("wrap_order%0d", k), got_rd[k], exp_rd[k]);
    chk("wrap_count", bus.wr_count_o, 5);
    chk("wrap_busy", bus.busy_o, 0);
    // reset mid-operation with pending execute and buffered load
    bus.ex_valid_i = 1'b1; bus.ex_rd_i = 5'd7; bus.ex_data_i = 32'h77;
    bus.ld_valid_i = 1'b1; bus.ld_rd_i = 5'd8; bus.ld_data_i = 32'h88;
    cyc();
    chk("pre_rst_wr_en", bus.wr_en_o, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_wr_en", bus.wr_en_o, 0);
    chk("mid_rst_rd_addr", bus.rd_addr_o, 0);
    chk("mid_rst_wr_data", bus.wr_data_o, 0);
    chk("mid_rst_count", bus.wr_count_o, 0);
    chk("mid_rst_busy", bus.busy_o, 0);
    chk("mid_rst_ex_ready", bus.ex_ready_o, 1);
    chk("mid_rst_ld_ready", bus.ld_ready_o, 1);
    bus.ex_valid_i = 1'b0; bus.ld_valid_i = 1'b0;
    cyc();
    reset = 1'b0;
    // 17 back-to-back writes wrap the 4-bit counter to 1
    bus.ex_valid_i = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      bus.ex_rd_i = 5'(k); bus.ex_data_i = 32'(k);
      cyc();
      chk($sformatf("stream_rd%0d", k), bus.rd_addr_o, 32'(k));
      chk($sformatf("stream_en%0d", k), bus.wr_en_o, 1);
    end
    bus.ex_valid_i = 1'b0;
    cyc();
    chk("cnt_wrap", bus.wr_count_o, 1);
    chk("cnt_wrap_busy", bus.busy_o, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
